cache_fill_writer: RTL and testbench

CACHE_FILL_WRITER -- requirements
Module: cache_fill_writer

---
 rtl/cache_fill_writer.sv | 114 +++++++++++
 tb/tb_cache_fill_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_writer.sv
// Cache refill writer: accepts one 512-bit line and writes it to the data blockram
// as four 128-bit quarters, critical quarter first, while flagging reads to that set.
module cache_fill_writer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fill_valid,
  output logic         fill_ready,
  input  logic [511:0] fill_line,
  input  logic [7:0]   fill_set,
  input  logic [1:0]   fill_way,
  input  logic [1:0]   fill_crit,
  output logic         wr_en,
  output logic [11:0]  wr_addr,
  output logic [127:0] wr_data,
  input  logic [9:0]   rd_addr,
  output logic         rd_hazard,
  output logic         fill_done,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Handshake: a line transfers on a rising edge where fill_valid && fill_ready;
  // fill_ready is high only in IDLE and does not depend on fill_valid, and the
  // fill_* inputs are sampled only at that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   beat, beat_nxt;
  logic [511:0] line_q;
  logic [7:0]   set_q;
  logic [1:0]   way_q;
  logic [1:0]   crit_q;
  logic [1:0]   quarter;
  logic         accept;
  logic         set_match;

  assign accept    = fill_valid && fill_ready;
  // 2-bit add wraps naturally, giving the critical-word-first order.
  assign quarter   = crit_q + beat;
  assign set_match = (rd_addr[9:2] == set_q);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Captured copy stays frozen until the next accepted line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      set_q  <= '0;
      way_q  <= '0;
      crit_q <= '0;
    end else if (accept) begin
      line_q <= fill_line;
      set_q  <= fill_set;
      way_q  <= fill_way;
      crit_q <= fill_crit;
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    fill_ready = 1'b0;
    busy       = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    fill_done  = 1'b0;
    rd_hazard  = 1'b0;
    case (state)
      IDLE: begin
        fill_ready = 1'b1;
        busy       = 1'b0;
        if (fill_valid) begin
          state_nxt = WRITE;
          beat_nxt  = 2'd0;
        end
      end
      WRITE: begin
        wr_en     = 1'b1;
        wr_addr   = {set_q, quarter, way_q};
        wr_data   = line_q[{quarter, 7'd0} +: 128];
        rd_hazard = set_match;
        beat_nxt  = beat + 2'd1;
        if (beat == 2'd3) begin
          state_nxt = DONE;
          beat_nxt  = 2'd0;
        end
      end
      DONE: begin
        fill_done = 1'b1;
        rd_hazard = set_match;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_writer.sv
// Bench for cache_fill_writer: directed fill table, back-pressure, hazard and
// mid-fill reset sequences, then a random fill scoreboard against a RAM model.
module tb_cache_fill_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fill_valid = 1'b0;
  logic         fill_ready;
  logic [511:0] fill_line = '0;
  logic [7:0]   fill_set = '0;
  logic [1:0]   fill_way = '0;
  logic [1:0]   fill_crit = '0;
  logic         wr_en;
  logic [11:0]  wr_addr;
  logic [127:0] wr_data;
  logic [9:0]   rd_addr = '0;
  logic         rd_hazard;
  logic         fill_done;
  logic         busy;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  cache_fill_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_line  (fill_line),
    .fill_set   (fill_set),
    .fill_way   (fill_way),
    .fill_crit  (fill_crit),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_hazard  (rd_hazard),
    .fill_done  (fill_done),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // Monitor state: RAM model built from observed writes, plus event counters.
  logic [511:0] ram [1024];
  logic [511:0] exp_mem [1024];
  logic [127:0] exp_q [$];
  logic [127:0] got_q [$];
  int           wr_cnt = 0;
  int           done_cnt = 0;
  bit           cap_en = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      ram[{wr_addr[11:4], wr_addr[1:0]}][{wr_addr[3:2], 7'd0} +: 128] = wr_data;
      if (cap_en) got_q.push_back(wr_data);
    end
    if (fill_done) done_cnt++;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] tag);
    logic [511:0] l;
    for (int q = 0; q < 4; q++)
      l[128*q +: 128] = {tag, 32'hC0DE0000 + 32'(q), ~tag, 32'h000000A0 + 32'(q)};
    return l;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  typedef struct {
    logic [7:0]        set;
    logic [1:0]        way;
    logic [1:0]        crit;
    logic [511:0]      line;
    logic [3:0][11:0]  addr;   // expected wr_addr per beat, beat 0 in [0]
  } vec_t;

  vec_t tbl [4];

  // Offers v in the current cycle and checks the full T..T+6 timeline.
  task automatic run_fill(input vec_t v, input string nm);
    int qq;
    fill_valid = 1'b1;
    fill_line  = v.line;
    fill_set   = v.set;
    fill_way   = v.way;
    fill_crit  = v.crit;
    chk({nm, " ready_before"}, fill_ready, 1'b1);
    step();
    fill_valid = 1'b0;
    fill_line  = ~v.line;
    for (int b = 0; b < 4; b++) begin
      qq = int'(v.addr[b][3:2]);
      chk($sformatf("%s b%0d wr_en", nm, b), wr_en, 1'b1);
      chk($sformatf("%s b%0d wr_addr", nm, b), wr_addr, v.addr[b]);
      chk($sformatf("%s b%0d wr_data", nm, b), wr_data, v.line[128*qq +: 128]);
      chk($sformatf("%s b%0d done", nm, b), fill_done, 1'b0);
      chk($sformatf("%s b%0d ready", nm, b), fill_ready, 1'b0);
      step();
    end
    chk({nm, " done_pulse"}, fill_done, 1'b1);
    chk({nm, " done_wr_en"}, wr_en, 1'b0);
    chk({nm, " done_wr_addr"}, wr_addr, 12'h0);
    chk({nm, " done_wr_data"}, wr_data, 128'h0);
    chk({nm, " done_busy"}, busy, 1'b1);
    step();
    chk({nm, " idle_ready"}, fill_ready, 1'b1);
    chk({nm, " idle_done"}, fill_done, 1'b0);
    chk({nm, " idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int acc [$];
    int t;
    logic [9:0] idx;

    tbl[0] = '{8'h3C, 2'd2, 2'd0, mk_line(32'h00003C00), {12'h3CE, 12'h3CA, 12'h3C6, 12'h3C2}};
    tbl[1] = '{8'hFF, 2'd3, 2'd3, mk_line(32'h0000FF00), {12'hFFB, 12'hFF7, 12'hFF3, 12'hFFF}};
    tbl[2] = '{8'h00, 2'd0, 2'd1, mk_line(32'h12345678), {12'h000, 12'h00C, 12'h008, 12'h004}};
    tbl[3] = '{8'hA5, 2'd1, 2'd2, mk_line(32'hDEADBEEF), {12'hA55, 12'hA51, 12'hA5D, 12'hA59}};

    // Reset state
    step();
    step();
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst wr_addr", wr_addr, 12'h0);
    chk("rst wr_data", wr_data, 128'h0);
    chk("rst fill_done", fill_done, 1'b0);
    chk("rst rd_hazard", rd_hazard, 1'b0);
    chk("rst busy", busy, 1'b0);
    rst_n = 1'b1;

    // Directed table; first offer goes on the first edge after release.
    for (int i = 0; i < 4; i++) run_fill(tbl[i], $sformatf("vec%0d", i));

    // Back-pressure: valid held high across two distinct lines.
    exp_q.delete();
    got_q.delete();
    for (int q = 0; q < 4; q++) exp_q.push_back(mk_line(32'h11111111)[128*q +: 128]);
    exp_q.push_back(mk_line(32'h22222222)[128*1 +: 128]);
    exp_q.push_back(mk_line(32'h22222222)[128*2 +: 128]);
    exp_q.push_back(mk_line(32'h22222222)[128*3 +: 128]);
    exp_q.push_back(mk_line(32'h22222222)[128*0 +: 128]);
    cap_en     = 1'b1;
    fill_valid = 1'b1;
    fill_line  = mk_line(32'h11111111);
    fill_set   = 8'h20;
    fill_way   = 2'd1;
    fill_crit  = 2'd0;
    for (int i = 0; i < 14; i++) begin
      if (fill_ready && fill_valid) acc.push_back(i);
      step();
      if (acc.size() == 1) begin
        fill_line = mk_line(32'h22222222);
        fill_set  = 8'h21;
        fill_way  = 2'd2;
        fill_crit = 2'd1;
      end else if (acc.size() == 2) begin
        fill_valid = 1'b0;
      end
    end
    cap_en = 1'b0;
    chk("bp accept_count", acc.size(), 2);
    if (acc.size() == 2) chk("bp spacing", acc[1] - acc[0], 6);
    chk("bp write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("bp data%0d", i), got_q[i], exp_q[i]);

    // Hazard snooping
    rd_addr    = 10'h041;
    fill_valid = 1'b1;
    fill_line  = mk_line(32'h10101010);
    fill_set   = 8'h10;
    fill_way   = 2'd0;
    fill_crit  = 2'd0;
    #1;
    chk("hz idle", rd_hazard, 1'b0);
    step();
    fill_valid = 1'b0;
    chk("hz write_match", rd_hazard, 1'b1);
    rd_addr = 10'h045;
    #1;
    chk("hz write_other_set", rd_hazard, 1'b0);
    rd_addr = 10'h042;
    #1;
    chk("hz write_low_bits", rd_hazard, 1'b1);
    rd_addr = 10'h041;
    step();
    step();
    step();
    step();
    chk("hz done_pulse", fill_done, 1'b1);
    chk("hz done_match", rd_hazard, 1'b1);
    step();
    chk("hz back_idle", rd_hazard, 1'b0);
    rd_addr = 10'h000;

    // Mid-fill reset after beat 1
    fill_valid = 1'b1;
    fill_line  = tbl[0].line;
    fill_set   = tbl[0].set;
    fill_way   = tbl[0].way;
    fill_crit  = tbl[0].crit;
    step();
    fill_valid = 1'b0;
    step();
    step();
    chk("mr beat2_wr_en", wr_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    wr_cnt   = 0;
    done_cnt = 0;
    chk("mr async_wr_en", wr_en, 1'b0);
    chk("mr async_wr_addr", wr_addr, 12'h0);
    chk("mr async_wr_data", wr_data, 128'h0);
    chk("mr async_busy", busy, 1'b0);
    step();
    step();
    step();
    chk("mr no_writes", wr_cnt, 0);
    chk("mr no_done", done_cnt, 0);
    rst_n = 1'b1;
    run_fill(tbl[3], "mr refill");

    // Random scoreboard against the RAM model
    for (int n = 0; n < 1000; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      fill_line  = rnd_line();
      fill_set   = 8'($urandom_range(0, 255));
      fill_way   = 2'($urandom_range(0, 3));
      fill_crit  = 2'($urandom_range(0, 3));
      idx        = {fill_set, fill_way};
      exp_mem[idx] = fill_line;
      wr_cnt     = 0;
      fill_valid = 1'b1;
      step();
      fill_valid = 1'b0;
      fill_line  = rnd_line();
      t = 0;
      while (!fill_ready && t < 12) begin
        step();
        t++;
      end
      chk($sformatf("rnd%0d ready_timeout", n), fill_ready, 1'b1);
      chk($sformatf("rnd%0d write_count", n), wr_cnt, 4);
      chk($sformatf("rnd%0d ram_line", n), ram[idx], exp_mem[idx]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
